// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-strobe input and committed-frame output stream of the UART frame controller.
// The slave modport is the controller; the master modport is the uart_rx/consumer side.
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    modport slave (
        input  rx_msg, rx_parity, rx_complete, out_ready,
        output out_data, out_last, out_valid, frame_done, frame_err, err_code
    );

    modport master (
        output rx_msg, rx_parity, rx_complete, out_ready,
        input  out_data, out_last, out_valid, frame_done, frame_err, err_code
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// SOF/EOF frame assembler behind uart_rx: payload is staged in a commit/rollback FIFO
// and only becomes visible to the consumer once its frame ends cleanly at EOF.
module uart_rx_frame_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAX_LEN = 8,
    parameter logic [7:0]  SOF     = 8'h23,
    parameter logic [7:0]  EOF     = 8'h0A,
    parameter logic [7:0]  PERR    = 8'h3F,
    parameter int unsigned TIMEOUT = 4000
) (
    input  logic                 clk_3125,
    input  logic                 rst,
    uart_rx_frame_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {HUNT, BODY, DISCARD} state_t;

    state_t        r_state;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_wr_tmp;
    logic [LW-1:0] r_len;
    logic [TW-1:0] r_timer;
    logic          r_frame_done;
    logic          r_frame_err;
    logic [1:0]    r_err_code;
    logic [8:0]    r_mem [DEPTH];

    state_t        w_state_n;
    logic [PW-1:0] w_wr_ptr_n;
    logic [PW-1:0] w_wr_tmp_n;
    logic [LW-1:0] w_len_n;
    logic [TW-1:0] w_timer_n;
    logic          w_we;
    logic [8:0]    w_wdata;
    logic          w_done_n;
    logic          w_abort;
    logic [1:0]    w_abort_code;
    logic          w_full;
    logic          w_valid;
    logic          w_pop;
    logic          w_strobe;
    logic [7:0]    w_b;

    // Occupancy counts tentative entries too, so an in-flight frame can't overwrite committed data.
    assign w_full   = (r_wr_tmp - r_rd_ptr) == PW'(DEPTH);
    assign w_valid  = (r_rd_ptr != r_wr_ptr);
    assign w_pop    = w_valid & bus.out_ready;
    assign w_strobe = bus.rx_complete;
    assign w_b      = bus.rx_msg;

    assign bus.out_valid  = w_valid;
    assign bus.out_data   = r_mem[r_rd_ptr[AW-1:0]][7:0];
    assign bus.out_last   = r_mem[r_rd_ptr[AW-1:0]][8];
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;
    assign bus.err_code   = r_err_code;

    always_comb begin
        w_state_n    = r_state;
        w_wr_ptr_n   = r_wr_ptr;
        w_wr_tmp_n   = r_wr_tmp;
        w_len_n      = r_len;
        w_timer_n    = r_timer;
        w_we         = 1'b0;
        w_wdata      = {1'b0, w_b};
        w_done_n     = 1'b0;
        w_abort      = 1'b0;
        w_abort_code = r_err_code;
        case (r_state)
            HUNT: begin
                if (w_strobe && w_b == SOF) begin
                    w_state_n = BODY;
                    w_len_n   = '0;
                    w_timer_n = '0;
                end
            end
            BODY: begin
                if (w_strobe) begin
                    w_timer_n = '0;
                    if (w_b == PERR) begin
                        w_abort      = 1'b1;
                        w_abort_code = 2'd0;
                        w_state_n    = DISCARD;
                    end else if (w_b == SOF) begin
                        w_abort      = 1'b1;
                        w_abort_code = 2'd3;
                        w_len_n      = '0;
                    end else if (w_b == EOF) begin
                        w_state_n = HUNT;
                        if (w_full) begin
                            w_abort      = 1'b1;
                            w_abort_code = 2'd2;
                        end else begin
                            w_we       = 1'b1;
                            w_wdata    = {1'b1, EOF};
                            w_wr_tmp_n = r_wr_tmp + PW'(1);
                            w_wr_ptr_n = r_wr_tmp + PW'(1);
                            w_done_n   = 1'b1;
                        end
                    end else if (r_len == LW'(MAX_LEN)) begin
                        w_abort      = 1'b1;
                        w_abort_code = 2'd1;
                        w_state_n    = DISCARD;
                    end else if (w_full) begin
                        w_abort      = 1'b1;
                        w_abort_code = 2'd2;
                        w_state_n    = DISCARD;
                    end else begin
                        w_we       = 1'b1;
                        w_wr_tmp_n = r_wr_tmp + PW'(1);
                        w_len_n    = r_len + LW'(1);
                    end
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_abort_code = 2'd3;
                    w_state_n    = HUNT;
                    w_timer_n    = '0;
                end else begin
                    w_timer_n = r_timer + TW'(1);
                end
            end
            DISCARD: begin
                if (w_strobe && w_b == EOF) begin
                    w_state_n = HUNT;
                end else if (w_strobe && w_b == SOF) begin
                    w_state_n = BODY;
                    w_len_n   = '0;
                    w_timer_n = '0;
                end
            end
            default: w_state_n = HUNT;
        endcase
        // Rollback drops only tentative entries; rd/wr pointers of committed data are untouched.
        if (w_abort) begin
            w_wr_tmp_n = r_wr_ptr;
        end
    end

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            r_state      <= HUNT;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_wr_tmp     <= '0;
            r_len        <= '0;
            r_timer      <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state      <= w_state_n;
            r_wr_ptr     <= w_wr_ptr_n;
            r_wr_tmp     <= w_wr_tmp_n;
            r_len        <= w_len_n;
            r_timer      <= w_timer_n;
            r_frame_done <= w_done_n;
            r_frame_err  <= w_abort;
            if (w_abort) begin
                r_err_code <= w_abort_code;
            end
            if (w_we) begin
                r_mem[r_wr_tmp[AW-1:0]] <= w_wdata;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end
endmodule
